// File: rtl/crc_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc_checker
// Brief    : Bit-serial MSB-first CRC checker for a received codeword under a
//            start/busy/done handshake. Optional error counter enabled by the
//            macro CRC_CHECKER_ERR_CNT_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module crc_checker #(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 4,
  parameter logic [CRC_W-1:0] POLY   = 4'b0011
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_W+CRC_W-1:0]   codeword_in,
  output logic                      busy,
  output logic                      done,
  output logic                      valid,
  output logic [CRC_W-1:0]          remainder
`ifdef CRC_CHECKER_ERR_CNT_EN
  ,
  output logic [15:0]               err_count
`endif
);

  localparam int c_cw    = DATA_W + CRC_W;
  localparam int c_cnt_w = $clog2(c_cw + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_cw - 1);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_shift = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [c_cw-1:0]    r_sr;
  logic [CRC_W-1:0]   r_rem;
  logic [CRC_W-1:0]   w_nr;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_accept;
  logic               w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (start) w_next_state = c_shift;
      c_shift: if (r_cnt == c_last) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    busy     = (r_state == c_shift);
    w_accept = (r_state == c_idle) && start;
    w_last   = (r_state == c_shift) && (r_cnt == c_last);
  end

  // One long-division step: shift the next codeword bit in, reduce on overflow.
  always_comb begin
    w_nr = {r_rem[CRC_W-2:0], r_sr[c_cw-1]} ^ (r_rem[CRC_W-1] ? POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr      <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      done      <= 1'b0;
      valid     <= 1'b0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_sr  <= codeword_in;
        r_rem <= '0;
        r_cnt <= '0;
        valid <= 1'b0;
      end else if (busy) begin
        r_sr  <= r_sr << 1;
        r_rem <= w_nr;
        r_cnt <= r_cnt + c_cnt_w'(1);
        if (w_last) begin
          remainder <= w_nr;
          valid     <= (w_nr == '0);
          done      <= 1'b1;
        end
      end
    end
  end

`ifdef CRC_CHECKER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (w_last && (w_nr != '0) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
